board_io_conditioner: RTL and testbench
=======================================

// Module: board_io_conditioner
// PURPOSE
//  N-channel board input conditioner and SoC reset sequencer for the FPGA board top.
//  Synchronises, optionally inverts and debounces raw switch/button pads.
//  Emits clean levels plus one-cycle rise/fall events per channel.
//  Replaces the direct ~pad_reset tie-off with a counted reset hold before soc_rst_n_o releases.
// PARAMETERS
//  NUM_CH           4      number of conditioned input channels (>=1)
//  SYNC_STAGES      2      synchroniser flops per channel (>=2)
//  DEBOUNCE_CYCLES  20000  consecutive stable cycles required to accept a new level (>=1)
//  RST_HOLD_CYCLES  16     cycles soc_rst_n_o stays low after pad_reset deasserts (>=1)
//  CH_INVERT        0      NUM_CH-bit mask; bit=1 inverts that raw input (active-low pads)
// PORTS
//  ref_clk      in   1       single clock, all logic on the rising edge
//  pad_reset    in   1       reset: synchronous, active-high; the board top synchronises the pad
//  raw_i        in   NUM_CH  raw asynchronous switch/button pads
//  db_enable_i  in   1       1 = debounce mode; 0 = bypass mode, synchronised level only
//  level_o      out  NUM_CH  conditioned level
//  rise_o       out  NUM_CH  one-cycle pulse on each accepted 0->1 transition of level_o
//  fall_o       out  NUM_CH  one-cycle pulse on each accepted 1->0 transition of level_o
//  soc_rst_n_o  out  1       active-low SoC reset; drives pulpissimo pad_reset_n
// BEHAVIOUR
//  Reset (pad_reset=1): sync flops, counters, level_o, rise_o and fall_o are cleared to 0.
//   soc_rst_n_o=0, FSM=ASSERT.
//  Input path: s = raw_i ^ CH_INVERT, passed through SYNC_STAGES flops to give sync[i].
//  Debounce mode, per channel:
//   - counter width CW = $clog2(DEBOUNCE_CYCLES+1).
//   - sync[i]==level_o[i]: cnt <= 0.
//   - sync[i]!=level_o[i]: cnt <= cnt+1.
//   - when cnt==DEBOUNCE_CYCLES-1 and the mismatch persists: level_o[i] toggles and cnt <= 0.
//   - any glitch back to level_o[i] before that point clears cnt.
//   - latency from a clean raw change to level_o: SYNC_STAGES+DEBOUNCE_CYCLES cycles.
//  Bypass mode (db_enable_i=0):
//   - level_o[i] <= sync[i]; latency SYNC_STAGES+1 cycles; all cnt held at 0.
//   - a mode change takes effect on the next edge; cnt values are cleared on it.
//  Events:
//   - rise_o/fall_o are registered and assert in the same cycle level_o changes, for exactly one cycle.
//   - channels are independent; simultaneous events on several channels are all reported.
//   - all events are forced to 0 while soc_rst_n_o=0; level_o still updates during HOLD.
//  Reset FSM (ASSERT -> HOLD -> RUN):
//   - ASSERT: soc_rst_n_o=0. pad_reset=0 sampled -> HOLD with hcnt=1.
//   - HOLD: soc_rst_n_o=0, hcnt increments each edge with pad_reset=0.
//     At hcnt==RST_HOLD_CYCLES -> RUN.
//   - RUN: soc_rst_n_o=1.
//   - net effect: soc_rst_n_o rises at the edge completing RST_HOLD_CYCLES consecutive samples of pad_reset=0.
//     With RST_HOLD_CYCLES=1 it rises on the first such edge.
//   - pad_reset=1 in any state -> ASSERT on the next edge (mid-hold restarts the full count);
//     soc_rst_n_o=0 in the same cycle.
//  No arithmetic wraps: cnt never exceeds DEBOUNCE_CYCLES-1, hcnt never exceeds RST_HOLD_CYCLES.
// TESTING (bench: NUM_CH=4, SYNC_STAGES=2, DEBOUNCE_CYCLES=8, RST_HOLD_CYCLES=16)
//  1 pad_reset=1 for 5 cycles, then 0 -> all outputs 0 throughout; soc_rst_n_o=1 after exactly 16 edges with pad_reset=0.
//  2 RUN, db_enable_i=1, raw_i[0] 0->1 held -> level_o[0]=1 and rise_o[0] pulse, 10 cycles after the change; no other channel moves.
//  3 raw_i[1] pattern: 5 high/3 low x4, then held high -> no event during the bounce; level_o[1] rises 10 cycles after the final rise.
//  4 CH_INVERT=4'b0001, raw_i[0]=1 idle -> level_o[0]=0; raw_i[0]->0 -> rise_o[0] after 10 cycles.
//  5 db_enable_i=0, raw_i[3] toggles once -> level_o[3] follows after 3 cycles with a one-cycle event.
//     Same cycle: raw_i[0] rises and raw_i[2] falls -> rise_o[0] and fall_o[2] pulse together.
//  6 pad_reset reasserted at hold edge 10 -> soc_rst_n_o stays 0; rises 16 edges after the re-release.
//     A button edge during HOLD updates level_o but produces no rise_o/fall_o.

Source files
------------

// File: rtl/board_io_conditioner.sv
// Board input conditioner: per-channel synchroniser, debouncer and edge events,
// plus the counted SoC reset release sequencer.
module board_io_conditioner #(
    parameter int                NUM_CH          = 4,
    parameter int                SYNC_STAGES     = 2,
    parameter int                DEBOUNCE_CYCLES = 20000,
    parameter int                RST_HOLD_CYCLES = 16,
    parameter logic [NUM_CH-1:0] CH_INVERT       = '0
) (
    input  logic              ref_clk,
    input  logic              pad_reset,
    input  logic [NUM_CH-1:0] raw_i,
    input  logic              db_enable_i,
    output logic [NUM_CH-1:0] level_o,
    output logic [NUM_CH-1:0] rise_o,
    output logic [NUM_CH-1:0] fall_o,
    output logic              soc_rst_n_o
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int HW = $clog2(RST_HOLD_CYCLES + 1);

    localparam logic [CW-1:0] CNT_LAST  = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_LAST = HW'(RST_HOLD_CYCLES);

    typedef enum logic [1:0] {
        ST_ASSERT,
        ST_HOLD,
        ST_RUN
    } rst_state_t;

    rst_state_t  state_q;
    rst_state_t  state_d;
    logic [HW-1:0] hcnt_q;
    logic [HW-1:0] hcnt_d;
    logic          run_d;

    logic [NUM_CH-1:0] sync_q [SYNC_STAGES];
    logic [NUM_CH-1:0] sync;
    logic [CW-1:0]     cnt_q  [NUM_CH];
    logic [CW-1:0]     cnt_d  [NUM_CH];
    logic [NUM_CH-1:0] level_d;

    // Reset sequencer
    always_ff @(posedge ref_clk) begin
        if (pad_reset) begin
            state_q <= ST_ASSERT;
            hcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        hcnt_d  = hcnt_q;
        unique case (state_q)
            ST_ASSERT: begin
                hcnt_d  = HW'(1);
                state_d = (hcnt_d == HOLD_LAST) ? ST_RUN : ST_HOLD;
            end
            ST_HOLD: begin
                hcnt_d  = hcnt_q + HW'(1);
                state_d = (hcnt_d == HOLD_LAST) ? ST_RUN : ST_HOLD;
            end
            ST_RUN: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_ASSERT;
                hcnt_d  = '0;
            end
        endcase
    end

    assign run_d       = (state_d == ST_RUN);
    assign soc_rst_n_o = (state_q == ST_RUN);

    // Synchroniser chain
    always_ff @(posedge ref_clk) begin
        if (pad_reset) begin
            for (int k = 0; k < SYNC_STAGES; k++) begin
                sync_q[k] <= '0;
            end
        end else begin
            sync_q[0] <= raw_i ^ CH_INVERT;
            for (int k = 1; k < SYNC_STAGES; k++) begin
                sync_q[k] <= sync_q[k-1];
            end
        end
    end

    assign sync = sync_q[SYNC_STAGES-1];

    // Bypass mode holds every counter at zero, so a mode switch always starts clean.
    always_comb begin
        level_d = level_o;
        for (int c = 0; c < NUM_CH; c++) begin
            cnt_d[c] = '0;
            if (!db_enable_i) begin
                level_d[c] = sync[c];
            end else if (sync[c] != level_o[c]) begin
                if (cnt_q[c] == CNT_LAST) begin
                    level_d[c] = ~level_o[c];
                end else begin
                    cnt_d[c] = cnt_q[c] + CW'(1);
                end
            end
        end
    end

    always_ff @(posedge ref_clk) begin
        if (pad_reset) begin
            level_o <= '0;
            rise_o  <= '0;
            fall_o  <= '0;
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= '0;
            end
        end else begin
            level_o <= level_d;
            rise_o  <= level_d & ~level_o & {NUM_CH{run_d}};
            fall_o  <= ~level_d & level_o & {NUM_CH{run_d}};
            for (int c = 0; c < NUM_CH; c++) begin
                cnt_q[c] <= cnt_d[c];
            end
        end
    end

endmodule

// File: tb/tb_board_io_conditioner.sv
// Randomised and directed bench for board_io_conditioner against a
// window-based behavioural model; two instances differ only in CH_INVERT.
module tb_board_io_conditioner;

    localparam int NCH = 4;
    localparam int SS  = 2;
    localparam int DB  = 8;
    localparam int RH  = 16;

    logic ref_clk = 1'b0;
    always #5 ref_clk = ~ref_clk;

    logic           pad_reset = 1'b1;
    logic [NCH-1:0] raw       = '0;
    logic           db_en     = 1'b1;

    logic [NCH-1:0] lvl0, r0, f0, lvl1, r1, f1;
    logic           srn0, srn1;

    board_io_conditioner #(
        .NUM_CH(NCH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB),
        .RST_HOLD_CYCLES(RH), .CH_INVERT(4'b0000)
    ) dut0 (
        .ref_clk(ref_clk), .pad_reset(pad_reset), .raw_i(raw),
        .db_enable_i(db_en), .level_o(lvl0), .rise_o(r0),
        .fall_o(f0), .soc_rst_n_o(srn0)
    );

    board_io_conditioner #(
        .NUM_CH(NCH), .SYNC_STAGES(SS), .DEBOUNCE_CYCLES(DB),
        .RST_HOLD_CYCLES(RH), .CH_INVERT(4'b0001)
    ) dut1 (
        .ref_clk(ref_clk), .pad_reset(pad_reset), .raw_i(raw),
        .db_enable_i(db_en), .level_o(lvl1), .rise_o(r1),
        .fall_o(f1), .soc_rst_n_o(srn1)
    );

    int checks   = 0;
    int failures = 0;
    bit done     = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: actual=%0h expected=%0h",
                     name, $time, act, exp);
        end
    endtask

    // Behavioural model: histories of samples, acceptance by window test
    logic [NCH-1:0] inv [2];
    initial begin
        inv[0] = 4'b0000;
        inv[1] = 4'b0001;
    end

    int             n  = 0;
    int             zc = 0;
    bit             m_run;
    bit             h_rst  [32];
    bit             h_db   [32];
    logic [NCH-1:0] h_s    [2][32];
    logic [NCH-1:0] h_sync [2][32];
    logic [NCH-1:0] m_lvl  [2];
    logic [NCH-1:0] m_rise [2];
    logic [NCH-1:0] m_fall [2];

    always @(posedge ref_clk) begin
        logic [NCH-1:0] sn;
        logic [NCH-1:0] nl;
        bit ok;
        n++;
        h_rst[n%32] = pad_reset;
        h_db[n%32]  = db_en;
        if (pad_reset) zc = 0;
        else if (zc < 1000) zc = zc + 1;
        m_run = (zc >= RH);
        for (int u = 0; u < 2; u++) begin
            h_s[u][n%32] = raw ^ inv[u];
            if (n >= 3 && !h_rst[(n-1)%32] && !h_rst[(n-2)%32])
                sn = h_s[u][(n-2)%32];
            else
                sn = '0;
            h_sync[u][n%32] = sn;
            if (pad_reset) begin
                m_lvl[u]  = '0;
                m_rise[u] = '0;
                m_fall[u] = '0;
            end else begin
                nl = m_lvl[u];
                for (int c = 0; c < NCH; c++) begin
                    if (!db_en) begin
                        nl[c] = sn[c];
                    end else begin
                        ok = 1;
                        for (int k = 0; k < DB; k++) begin
                            if (k >= n) ok = 0;
                            else if (h_rst[(n-k)%32] || !h_db[(n-k)%32] ||
                                     h_sync[u][(n-k)%32][c] == m_lvl[u][c])
                                ok = 0;
                        end
                        if (ok) nl[c] = ~m_lvl[u][c];
                    end
                end
                m_rise[u] = m_run ? (nl & ~m_lvl[u]) : '0;
                m_fall[u] = m_run ? (~nl & m_lvl[u]) : '0;
                m_lvl[u]  = nl;
            end
        end
    end

    always @(negedge ref_clk) begin
        if (n >= 1 && !done) begin
            chk("level0", lvl0, m_lvl[0]);
            chk("rise0",  r0,   m_rise[0]);
            chk("fall0",  f0,   m_fall[0]);
            chk("srn0",   srn0, m_run);
            chk("level1", lvl1, m_lvl[1]);
            chk("rise1",  r1,   m_rise[1]);
            chk("fall1",  f1,   m_fall[1]);
            chk("srn1",   srn1, m_run);
        end
    end

    initial begin
        int first;
        int cnt;
        int other;
        int seen;
        int calm;

        // 1: reset then counted release
        repeat (5) @(negedge ref_clk);
        chk("reset_outputs", {lvl0, r0, f0, 3'b0, srn0}, 0);
        pad_reset = 1'b0;
        first = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge ref_clk);
            if (srn0 && first == 0) first = i;
        end
        chk("hold_len", first, 16);

        // 2: single clean rise on channel 0
        raw[0] = 1'b1;
        first = 0;
        other = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge ref_clk);
            if (lvl0[0] && first == 0) begin
                first = i;
                chk("s2_rise_pulse", r0[0], 1);
            end
            if (lvl0[3:1] != 3'b000 || r0[3:1] != 3'b000) other = 1;
        end
        chk("s2_latency", first, 10);
        chk("s2_others", other, 0);
        chk("s4_inv_idle", lvl1[0], 0);

        // 3: bouncing channel 1
        cnt = 0;
        for (int rep = 0; rep < 4; rep++) begin
            raw[1] = 1'b1;
            repeat (5) begin
                @(negedge ref_clk);
                cnt += int'(r0[1]);
            end
            raw[1] = 1'b0;
            repeat (3) begin
                @(negedge ref_clk);
                cnt += int'(r0[1]);
            end
        end
        raw[1] = 1'b1;
        first = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge ref_clk);
            cnt += int'(r0[1]);
            if (lvl0[1] && first == 0) first = i;
        end
        chk("s3_latency", first, 10);
        chk("s3_rise_count", cnt, 1);

        // 4: inverted channel rises when pad goes low
        raw[0] = 1'b0;
        first = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge ref_clk);
            if (r1[0] && first == 0) first = i;
        end
        chk("s4_inv_rise", first, 10);

        // 5: bypass mode
        db_en = 1'b0;
        repeat (6) @(negedge ref_clk);
        raw[3] = 1'b1;
        first = 0;
        for (int i = 1; i <= 10; i++) begin
            @(negedge ref_clk);
            if (lvl0[3] && first == 0) begin
                first = i;
                chk("s5_rise3", r0[3], 1);
            end
        end
        chk("s5_latency", first, 3);
        raw[2] = 1'b1;
        repeat (6) @(negedge ref_clk);
        raw[0] = 1'b1;
        raw[2] = 1'b0;
        repeat (3) @(negedge ref_clk);
        chk("s5_simul", {r0[0], f0[2]}, 2'b11);

        // 6: reset restarted mid-hold
        pad_reset = 1'b1;
        repeat (2) @(negedge ref_clk);
        pad_reset = 1'b0;
        seen = 0;
        repeat (9) begin
            @(negedge ref_clk);
            seen |= int'(srn0);
        end
        pad_reset = 1'b1;
        @(negedge ref_clk);
        seen |= int'(srn0);
        pad_reset = 1'b0;
        chk("s6_restart_low", seen, 0);
        first = 0;
        cnt = 0;
        for (int i = 1; i <= 40; i++) begin
            @(negedge ref_clk);
            if (i == 2) raw[3] = 1'b0;
            if (!srn0) cnt += $countones({r0, f0});
            if (i == 10) chk("s6_hold_level3", lvl0[3], 0);
            if (srn0 && first == 0) first = i;
        end
        chk("s6_hold_len", first, 16);
        chk("s6_hold_events", cnt, 0);

        // Random phase
        db_en = 1'b1;
        calm = 1;
        for (int it = 0; it < 4000; it++) begin
            @(negedge ref_clk);
            if (it % 100 == 0) calm = ($urandom_range(0, 1) == 0) ? 1 : 0;
            if (pad_reset && $urandom_range(0, 2) == 0) pad_reset = 1'b0;
            else if ($urandom_range(0, 499) == 0) pad_reset = 1'b1;
            if ($urandom_range(0, 149) == 0) db_en = ~db_en;
            for (int c = 0; c < NCH; c++) begin
                if ($urandom_range(0, calm ? 24 : 2) == 0) raw[c] = ~raw[c];
            end
        end

        done = 1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
